// File: rtl/switch_pkg.sv
// Shared definitions for the 4x4 switch daemons: word/header layout, FSM states
// and the header decode helper.
package switch_pkg;

    localparam int DATA_W    = 32;
    localparam int LEN_W     = 8;
    localparam int NUM_PORTS = 4;
    localparam int DEST_W    = 2;

    localparam int RSVD_MSB  = 31;
    localparam int RSVD_LSB  = 26;
    localparam int DEST_MSB  = 25;
    localparam int DEST_LSB  = 24;
    localparam int LEN_MSB   = 7;
    localparam int LEN_LSB   = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        DROP  = 2'd2
    } state_t;

    typedef struct packed {
        logic              malformed;
        logic [DEST_W-1:0] dest;
        logic [LEN_W-1:0]  len;
    } hdr_t;

    function automatic hdr_t decode_hdr(input logic [DATA_W-1:0] word);
        hdr_t h;
        h.malformed = |word[RSVD_MSB:RSVD_LSB];
        h.dest      = word[DEST_MSB:DEST_LSB];
        h.len       = word[LEN_MSB:LEN_LSB];
        return h;
    endfunction

endpackage

// File: rtl/hdr_decode.sv
// Combinational header field extraction; only meaningful when the word
// presented is in a header position.
module hdr_decode
    import switch_pkg::*;
(
    input  logic [DATA_W-1:0] word,
    output hdr_t              hdr
);

    assign hdr = decode_hdr(word);

endmodule

// File: rtl/input_daemon.sv
// Ingress steering for one switch input: decodes headers, forwards packets to
// one of four queue feeds with backpressure, and discards malformed packets.
//
// state | meaning
// IDLE  | next accepted word is a header
// ROUTE | forwarding payload words to the latched destination queue
// DROP  | discarding the payload of a malformed packet
module input_daemon #(
    parameter int DATA_W     = switch_pkg::DATA_W,
    parameter int LEN_W      = switch_pkg::LEN_W,
    parameter int DROP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W:0]       INPUT_PORT,
    output logic                  INPUT_READY,
    input  logic [3:0]            QUEUE_FULL,
    output logic [DATA_W:0]       TO_QUEUE_1,
    output logic [DATA_W:0]       TO_QUEUE_2,
    output logic [DATA_W:0]       TO_QUEUE_3,
    output logic [DATA_W:0]       TO_QUEUE_4,
    output logic                  PKT_DONE,
    output logic [DROP_CNT_W-1:0] DROP_COUNT
);

    localparam int NP = switch_pkg::NUM_PORTS;

    switch_pkg::state_t      state, state_n;
    switch_pkg::hdr_t        hdr;
    logic [1:0]              dest_r;
    logic [LEN_W-1:0]        rem_r;
    logic [DATA_W:0]         q_r [NP];
    logic                    done_r;
    logic [DROP_CNT_W-1:0]   drop_r;

    logic                    in_valid;
    logic                    ready;
    logic                    fwd;
    logic [1:0]              fwd_dest;
    logic                    last;
    logic                    drop_hdr;
    logic                    load_hdr;
    logic                    dec;

    hdr_decode u_hdr_decode (
        .word (INPUT_PORT[DATA_W-1:0]),
        .hdr  (hdr)
    );

    assign in_valid = INPUT_PORT[DATA_W];

    always_comb begin
        state_n  = state;
        ready    = 1'b0;
        fwd      = 1'b0;
        fwd_dest = dest_r;
        last     = 1'b0;
        drop_hdr = 1'b0;
        load_hdr = 1'b0;
        dec      = 1'b0;
        case (state)
            switch_pkg::IDLE: begin
                // a malformed header is always swallowed, whatever its dest field says
                ready = hdr.malformed ? 1'b1 : !QUEUE_FULL[hdr.dest];
                if (in_valid && ready) begin
                    load_hdr = 1'b1;
                    if (hdr.malformed) begin
                        drop_hdr = 1'b1;
                        if (hdr.len != '0) state_n = switch_pkg::DROP;
                    end else begin
                        fwd      = 1'b1;
                        fwd_dest = hdr.dest;
                        if (hdr.len == '0) last = 1'b1;
                        else               state_n = switch_pkg::ROUTE;
                    end
                end
            end
            switch_pkg::ROUTE: begin
                ready = !QUEUE_FULL[dest_r];
                if (in_valid && ready) begin
                    fwd = 1'b1;
                    dec = 1'b1;
                    if (rem_r <= LEN_W'(1)) begin
                        last    = 1'b1;
                        state_n = switch_pkg::IDLE;
                    end
                end
            end
            switch_pkg::DROP: begin
                ready = 1'b1;
                if (in_valid) begin
                    dec = 1'b1;
                    if (rem_r <= LEN_W'(1)) state_n = switch_pkg::IDLE;
                end
            end
            default: state_n = switch_pkg::IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= switch_pkg::IDLE;
            dest_r <= '0;
            rem_r  <= '0;
            done_r <= 1'b0;
            drop_r <= '0;
            for (int k = 0; k < NP; k++) q_r[k] <= '0;
        end else begin
            state  <= state_n;
            done_r <= last;
            for (int k = 0; k < NP; k++)
                q_r[k] <= (fwd && fwd_dest == 2'(k)) ? {1'b1, INPUT_PORT[DATA_W-1:0]} : '0;
            if (load_hdr) begin
                rem_r <= LEN_W'(hdr.len);
                if (!hdr.malformed) dest_r <= hdr.dest;
            end else if (dec && rem_r != '0) begin
                rem_r <= rem_r - LEN_W'(1);
            end
            if (drop_hdr && drop_r != '1) drop_r <= drop_r + DROP_CNT_W'(1);
        end
    end

    assign INPUT_READY = ready;
    assign TO_QUEUE_1  = q_r[0];
    assign TO_QUEUE_2  = q_r[1];
    assign TO_QUEUE_3  = q_r[2];
    assign TO_QUEUE_4  = q_r[3];
    assign PKT_DONE    = done_r;
    assign DROP_COUNT  = drop_r;

endmodule

// File: tb/tb_input_daemon.sv
// Directed bench for input_daemon: packet-level reference model checked every
// cycle, plus literal expectations at key points of each scenario.
module tb_input_daemon;

    logic        clk = 1'b0;
    logic        rst;
    logic [32:0] INPUT_PORT;
    logic        INPUT_READY;
    logic [3:0]  QUEUE_FULL;
    logic [32:0] TO_QUEUE_1, TO_QUEUE_2, TO_QUEUE_3, TO_QUEUE_4;
    logic        PKT_DONE;
    logic [7:0]  DROP_COUNT;

    int n_cmp = 0;
    int n_err = 0;

    input_daemon dut (
        .clk         (clk),
        .rst         (rst),
        .INPUT_PORT  (INPUT_PORT),
        .INPUT_READY (INPUT_READY),
        .QUEUE_FULL  (QUEUE_FULL),
        .TO_QUEUE_1  (TO_QUEUE_1),
        .TO_QUEUE_2  (TO_QUEUE_2),
        .TO_QUEUE_3  (TO_QUEUE_3),
        .TO_QUEUE_4  (TO_QUEUE_4),
        .PKT_DONE    (PKT_DONE),
        .DROP_COUNT  (DROP_COUNT)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the packet stream says should leave each cycle.
    int          m_mode;   // 0 expecting header, 1 forwarding, 2 discarding
    int          m_left;
    int          m_dest;
    logic [32:0] e_q [4];
    bit          e_done;
    int          e_drop;

    function automatic bit m_ready();
        logic [31:0] w;
        w = INPUT_PORT[31:0];
        if (m_mode == 1) return !QUEUE_FULL[m_dest];
        if (m_mode == 2) return 1'b1;
        if (w[31:26] != 6'd0) return 1'b1;
        return !QUEUE_FULL[w[25:24]];
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode = 0; m_left = 0; m_dest = 0; e_done = 0; e_drop = 0;
            for (int k = 0; k < 4; k++) e_q[k] = '0;
        end else begin
            logic [31:0] w;
            bit acc;
            w   = INPUT_PORT[31:0];
            acc = INPUT_PORT[32] && m_ready();
            for (int k = 0; k < 4; k++) e_q[k] = '0;
            e_done = 0;
            if (acc) begin
                if (m_mode == 0) begin
                    m_left = int'(w[7:0]);
                    if (w[31:26] != 6'd0) begin
                        if (e_drop < 255) e_drop++;
                        m_mode = (m_left > 0) ? 2 : 0;
                    end else begin
                        m_dest = int'(w[25:24]);
                        e_q[m_dest] = {1'b1, w};
                        if (m_left == 0) e_done = 1;
                        else             m_mode = 1;
                    end
                end else if (m_mode == 1) begin
                    e_q[m_dest] = {1'b1, w};
                    m_left--;
                    if (m_left == 0) begin e_done = 1; m_mode = 0; end
                end else begin
                    m_left--;
                    if (m_left == 0) m_mode = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("ready", 64'(INPUT_READY), 64'(m_ready()));
        chk("q1", 64'(TO_QUEUE_1), 64'(e_q[0]));
        chk("q2", 64'(TO_QUEUE_2), 64'(e_q[1]));
        chk("q3", 64'(TO_QUEUE_3), 64'(e_q[2]));
        chk("q4", 64'(TO_QUEUE_4), 64'(e_q[3]));
        chk("pkt_done", 64'(PKT_DONE), 64'(e_done));
        chk("drop_count", 64'(DROP_COUNT), 64'(e_drop));
    end

    // Present a word; hold QUEUE_FULL=fm for fc cycles; return once accepted.
    task automatic send(input logic [31:0] w, input logic [3:0] fm, input int fc, output int cyc);
        bit rdy;
        INPUT_PORT = {1'b1, w};
        QUEUE_FULL = (fc > 0) ? fm : 4'd0;
        cyc = 0;
        rdy = 0;
        while (!rdy) begin
            @(negedge clk);
            rdy = INPUT_READY;
            @(posedge clk);
            #1;
            cyc++;
            if (cyc >= fc) QUEUE_FULL = 4'd0;
            if (cyc > 20) begin
                chk("accept_timeout", 64'(cyc), 64'd0);
                rdy = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        INPUT_PORT = '0;
        QUEUE_FULL = '0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    int c;

    initial begin
        rst = 1'b0;
        INPUT_PORT = '0;
        QUEUE_FULL = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q4", 64'(TO_QUEUE_4), 64'h0);
        chk("rst_drop", 64'(DROP_COUNT), 64'h0);
        rst = 1'b1;
        idle(1);

        // header to queue 4 with one payload word
        send(32'h03000501, 4'h0, 0, c);
        chk("t1_hdr", 64'(TO_QUEUE_4), 64'h103000501);
        chk("t1_hdr_q1", 64'(TO_QUEUE_1), 64'h0);
        send(32'h00000020, 4'h0, 0, c);
        chk("t1_pay", 64'(TO_QUEUE_4), 64'h100000020);
        chk("t1_done", 64'(PKT_DONE), 64'd1);
        idle(2);

        // queue 2 packet, non-destination full ignored, destination stall of 2 cycles
        send(32'h01000003, 4'h0, 0, c);
        send(32'd10, 4'b1000, 2, c);
        chk("t2_nondest_full", 64'(c), 64'd1);
        send(32'd7, 4'b0010, 2, c);
        chk("t2_stall_cycles", 64'(c), 64'd3);
        chk("t2_word7", 64'(TO_QUEUE_2), 64'h100000007);
        send(32'd128, 4'h0, 0, c);
        chk("t2_last", 64'(TO_QUEUE_2), 64'h100000080);
        chk("t2_done", 64'(PKT_DONE), 64'd1);
        idle(1);

        // L=0 header back-to-back with a new packet
        send(32'h00000000, 4'h0, 0, c);
        chk("t3_q1", 64'(TO_QUEUE_1), 64'h100000000);
        chk("t3_done0", 64'(PKT_DONE), 64'd1);
        send(32'h02000001, 4'h0, 0, c);
        chk("t3_no_bubble", 64'(c), 64'd1);
        chk("t3_q3_hdr", 64'(TO_QUEUE_3), 64'h102000001);
        chk("t3_done_mid", 64'(PKT_DONE), 64'd0);
        send(32'd200, 4'h0, 0, c);
        chk("t3_q3_pay", 64'(TO_QUEUE_3), 64'h1000000C8);
        chk("t3_done1", 64'(PKT_DONE), 64'd1);

        // malformed packet with header-looking payload, then a normal header
        send(32'h40000002, 4'h0, 0, c);
        chk("t4_drop", 64'(DROP_COUNT), 64'd1);
        send(32'h03000001, 4'h0, 0, c);
        chk("t4_disc_q4", 64'(TO_QUEUE_4), 64'h0);
        send(32'h01000000, 4'h0, 0, c);
        chk("t4_disc_q2", 64'(TO_QUEUE_2), 64'h0);
        send(32'h01000000, 4'h0, 0, c);
        chk("t4_route", 64'(TO_QUEUE_2), 64'h101000000);
        idle(1);

        // asynchronous reset mid-packet
        send(32'h01000005, 4'h0, 0, c);
        send(32'h11111111, 4'h0, 0, c);
        #2 rst = 1'b0;
        #1;
        chk("t5_q2_zero", 64'(TO_QUEUE_2), 64'h0);
        chk("t5_drop_zero", 64'(DROP_COUNT), 64'h0);
        @(posedge clk);
        #2 rst = 1'b1;
        send(32'h02000000, 4'h0, 0, c);
        chk("t5_hdr_after_rst", 64'(TO_QUEUE_3), 64'h102000000);
        chk("t5_done", 64'(PKT_DONE), 64'd1);
        idle(1);

        // drop counter saturation
        for (int i = 0; i < 300; i++) send(32'h04000000, 4'h0, 0, c);
        chk("t6_sat", 64'(DROP_COUNT), 64'd255);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
